// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle simple ops, iterative signed shift-add MUL.
// Optional restoring signed DIV is compiled in with macro MC_ALU_DIV_EN.
module mc_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             div_by_zero
);
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
`ifdef MC_ALU_DIV_EN
    localparam logic [3:0] OP_DIV = 4'b1001;
`endif
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
    logic [SHW-1:0]   cnt;
    logic             neg_lo_q;
    logic [WIDTH-1:0] result_q, result_hi_q;
    logic             zero_q, dbz_q;

    logic             accept, go_run, last_step, div0, is_div_op;
    logic [WIDTH-1:0] simple_res, imm_res, imm_hi;
    logic [WIDTH-1:0] mag_a, mag_b, run_lo_init, run_opnd_init;
    logic [WIDTH-1:0] step_hi, step_lo, fin_lo, fin_hi;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic [2*WIDTH-1:0] prod_s;

    assign accept    = start && (state != RUN);
    assign last_step = (state == RUN) && (cnt == SHW'(WIDTH-1));
    assign mag_a     = a[WIDTH-1] ? -a : a;
    assign mag_b     = b[WIDTH-1] ? -b : b;

    always_comb begin
        simple_res = '0;
        case (op)
            OP_ADD:  simple_res = a + b;
            OP_SUB:  simple_res = b - a;
            OP_AND:  simple_res = a & b;
            OP_OR:   simple_res = a | b;
            OP_SLL:  simple_res = (b >= W_VAL) ? '0 : a << b[SHW-1:0];
            OP_SRL:  simple_res = (b >= W_VAL) ? '0 : a >> b[SHW-1:0];
            OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(b) < $signed(a))};
            default: simple_res = '0;
        endcase
    end

    // One shift-add step: {hi,lo} holds partial product over multiplier bits.
    always_comb begin
        mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
        mul_hi  = mul_sum[WIDTH:1];
        mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end

`ifdef MC_ALU_DIV_EN
    logic             neg_hi_q, is_div_q;
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi, div_lo;

    assign is_div_op = (op == OP_DIV);
    assign div0      = is_div_op && (b == '0);

    // Restoring step on magnitudes: hi is the partial remainder, lo shifts out dividend bits.
    always_comb begin
        div_shift     = {hi_q, lo_q[WIDTH-1]};
        div_diff      = div_shift - {1'b0, opnd_q};
        div_ge        = div_shift >= {1'b0, opnd_q};
        div_hi        = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_lo        = {lo_q[WIDTH-2:0], div_ge};
        step_hi       = is_div_q ? div_hi : mul_hi;
        step_lo       = is_div_q ? div_lo : mul_lo;
        prod_s        = neg_lo_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        fin_lo        = is_div_q ? (neg_lo_q ? -step_lo : step_lo) : prod_s[WIDTH-1:0];
        fin_hi        = is_div_q ? (neg_hi_q ? -step_hi : step_hi) : prod_s[2*WIDTH-1:WIDTH];
        run_lo_init   = is_div_op ? mag_a : mag_b;
        run_opnd_init = is_div_op ? mag_b : mag_a;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_hi_q <= 1'b0;
            is_div_q <= 1'b0;
        end else if (accept && go_run) begin
            neg_hi_q <= a[WIDTH-1];
            is_div_q <= is_div_op;
        end
    end
`else
    assign is_div_op = 1'b0;
    assign div0      = 1'b0;

    always_comb begin
        step_hi       = mul_hi;
        step_lo       = mul_lo;
        prod_s        = neg_lo_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        fin_lo        = prod_s[WIDTH-1:0];
        fin_hi        = prod_s[2*WIDTH-1:WIDTH];
        run_lo_init   = mag_b;
        run_opnd_init = mag_a;
    end
`endif

    assign go_run  = (op == OP_MUL) || (is_div_op && !div0);
    assign imm_res = div0 ? '1 : simple_res;
    assign imm_hi  = div0 ? a : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = go_run ? RUN : DONE;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = start ? (go_run ? RUN : DONE) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            cnt         <= '0;
            neg_lo_q    <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b1;
            dbz_q       <= 1'b0;
        end else if (accept) begin
            if (go_run) begin
                hi_q     <= '0;
                lo_q     <= run_lo_init;
                opnd_q   <= run_opnd_init;
                cnt      <= '0;
                neg_lo_q <= a[WIDTH-1] ^ b[WIDTH-1];
            end else begin
                result_q    <= imm_res;
                result_hi_q <= imm_hi;
                zero_q      <= (imm_res == '0);
                dbz_q       <= div0;
            end
        end else if (state == RUN) begin
            hi_q <= step_hi;
            lo_q <= step_lo;
            cnt  <= cnt + 1'b1;
            if (last_step) begin
                result_q    <= fin_lo;
                result_hi_q <= fin_hi;
                zero_q      <= (fin_lo == '0);
                dbz_q       <= 1'b0;
            end
        end
    end

    assign busy        = (state == RUN);
    assign done        = (state == DONE);
    assign result      = result_q;
    assign result_hi   = result_hi_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_mc_alu.sv
// Directed bench for mc_alu (WIDTH=16); DIV cases depend on MC_ALU_DIV_EN.
module tb_mc_alu;
    localparam int W = 16;
    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, AND_ = 4'b0010, OR_ = 4'b0011,
                           SLL = 4'b0101, SRL = 4'b0110, SLT = 4'b0111, MUL = 4'b1000,
                           DIV = 4'b1001;

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, zero, div_by_zero;
    logic [W-1:0] result, result_hi;
    int checks = 0, errors = 0;

    mc_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .result_hi(result_hi),
        .zero(zero), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Issue one op and wait for done; lat counts edges from the start edge, bc counts busy cycles.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output int bc);
        @(negedge clk); op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; lat = 1; bc = 0;
        while (!done && lat < 64) begin
            if (busy) bc++;
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (result !== 16'h0) begin errors++; $display("FAIL reset_result got %h want 0000", result); end
        checks++; if (result_hi !== 16'h0) begin errors++; $display("FAIL reset_result_hi got %h want 0000", result_hi); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b want 1", zero); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_simple;
        int lat, bc;
        run_op(ADD, 16'h7FFF, 16'h0001, lat, bc);
        checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d want 1", lat); end
        checks++; if (result !== 16'h8000) begin errors++; $display("FAIL add_result got %h want 8000", result); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL add_zero got %b want 0", zero); end
        checks++; if (result_hi !== 16'h0) begin errors++; $display("FAIL add_hi got %h want 0000", result_hi); end
        run_op(SUB, 16'h0003, 16'h000A, lat, bc);
        checks++; if (result !== 16'h0007) begin errors++; $display("FAIL sub_result got %h want 0007", result); end
        run_op(SUB, 16'h0001, 16'h0000, lat, bc);
        checks++; if (result !== 16'hFFFF) begin errors++; $display("FAIL sub_wrap got %h want ffff", result); end
        run_op(AND_, 16'hF0F0, 16'hFF00, lat, bc);
        checks++; if (result !== 16'hF000) begin errors++; $display("FAIL and_result got %h want f000", result); end
        run_op(SLT, 16'hFFFE, 16'h0003, lat, bc);
        checks++; if (result !== 16'h0000 || zero !== 1'b1) begin errors++; $display("FAIL slt_false got %h/%b want 0000/1", result, zero); end
        run_op(4'b0100, 16'h0005, 16'h0005, lat, bc);
        checks++; if (result !== 16'h0 || result_hi !== 16'h0 || zero !== 1'b1 || lat !== 1) begin
            errors++; $display("FAIL undef_op got %h/%h/%b lat %0d want 0000/0000/1 lat 1", result, result_hi, zero, lat); end
    endtask

    task automatic test_shift;
        int lat, bc;
        run_op(SLL, 16'h0001, 16'h0010, lat, bc);
        checks++; if (result !== 16'h0000 || zero !== 1'b1) begin errors++; $display("FAIL sll_oob got %h/%b want 0000/1", result, zero); end
        run_op(SLL, 16'h0003, 16'h0004, lat, bc);
        checks++; if (result !== 16'h0030) begin errors++; $display("FAIL sll_4 got %h want 0030", result); end
        run_op(SRL, 16'h8000, 16'h000F, lat, bc);
        checks++; if (result !== 16'h0001) begin errors++; $display("FAIL srl_15 got %h want 0001", result); end
        run_op(SRL, 16'hFFFF, 16'h0100, lat, bc);
        checks++; if (result !== 16'h0000) begin errors++; $display("FAIL srl_oob got %h want 0000", result); end
    endtask

    task automatic test_mul;
        int lat, bc;
        run_op(MUL, 16'hFFFD, 16'h0007, lat, bc);
        checks++; if (lat !== 17) begin errors++; $display("FAIL mul_latency got %0d want 17", lat); end
        checks++; if (bc !== 16) begin errors++; $display("FAIL mul_busy_cycles got %0d want 16", bc); end
        checks++; if (result !== 16'hFFEB || result_hi !== 16'hFFFF) begin
            errors++; $display("FAIL mul_neg got %h:%h want ffff:ffeb", result_hi, result); end
        run_op(MUL, 16'h8000, 16'h8000, lat, bc);
        checks++; if (result !== 16'h0000 || result_hi !== 16'h4000 || zero !== 1'b1) begin
            errors++; $display("FAIL mul_minmin got %h:%h z%b want 4000:0000 z1", result_hi, result, zero); end
        run_op(MUL, 16'h0100, 16'h0100, lat, bc);
        checks++; if (result !== 16'h0000 || result_hi !== 16'h0001) begin
            errors++; $display("FAIL mul_carry got %h:%h want 0001:0000", result_hi, result); end
        run_op(MUL, 16'h7FFF, 16'hFFFF, lat, bc);
        checks++; if (result !== 16'h8001 || result_hi !== 16'hFFFF || zero !== 1'b0) begin
            errors++; $display("FAIL mul_by_m1 got %h:%h want ffff:8001", result_hi, result); end
    endtask

    task automatic test_div;
        int lat, bc;
`ifdef MC_ALU_DIV_EN
        run_op(DIV, 16'hFFF9, 16'h0002, lat, bc);
        checks++; if (lat !== 17 || result !== 16'hFFFD || result_hi !== 16'hFFFF) begin
            errors++; $display("FAIL div_neg got lat %0d %h r %h want lat 17 fffd r ffff", lat, result, result_hi); end
        run_op(DIV, 16'hFFF9, 16'h0000, lat, bc);
        checks++; if (lat !== 1 || result !== 16'hFFFF || result_hi !== 16'hFFF9 || div_by_zero !== 1'b1) begin
            errors++; $display("FAIL div_zero got lat %0d %h r %h dbz %b want lat 1 ffff r fff9 dbz 1", lat, result, result_hi, div_by_zero); end
        run_op(DIV, 16'h8000, 16'hFFFF, lat, bc);
        checks++; if (result !== 16'h8000 || result_hi !== 16'h0000 || div_by_zero !== 1'b0) begin
            errors++; $display("FAIL div_ovf got %h r %h dbz %b want 8000 r 0000 dbz 0", result, result_hi, div_by_zero); end
        run_op(DIV, 16'd100, 16'd7, lat, bc);
        checks++; if (result !== 16'd14 || result_hi !== 16'd2) begin
            errors++; $display("FAIL div_pos got %h r %h want 000e r 0002", result, result_hi); end
        run_op(DIV, 16'd7, 16'hFFFE, lat, bc);
        checks++; if (result !== 16'hFFFD || result_hi !== 16'h0001) begin
            errors++; $display("FAIL div_negb got %h r %h want fffd r 0001", result, result_hi); end
`else
        run_op(DIV, 16'h0007, 16'h0002, lat, bc);
        checks++; if (lat !== 1 || result !== 16'h0 || result_hi !== 16'h0 || zero !== 1'b1) begin
            errors++; $display("FAIL div_undef got lat %0d %h/%h/%b want lat 1 0000/0000/1", lat, result, result_hi, zero); end
        run_op(DIV, 16'h0007, 16'h0000, lat, bc);
        checks++; if (div_by_zero !== 1'b0 || result !== 16'h0) begin
            errors++; $display("FAIL div_undef_b0 got %h dbz %b want 0000 dbz 0", result, div_by_zero); end
`endif
    endtask

    task automatic test_ignore_start;
        int lat;
        @(negedge clk); op = MUL; a = 16'hFFFD; b = 16'h0007; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; lat = 1;
        repeat (3) begin @(posedge clk); #1; lat++; end
        @(negedge clk); op = ADD; a = 16'h0001; b = 16'h0001; start = 1'b1;
        @(posedge clk); #1; lat++; start = 1'b0;
        while (!done && lat < 64) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 17) begin errors++; $display("FAIL ignore_latency got %0d want 17", lat); end
        checks++; if (result !== 16'hFFEB || result_hi !== 16'hFFFF) begin
            errors++; $display("FAIL ignore_result got %h:%h want ffff:ffeb", result_hi, result); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL ignore_no_queue got done %b busy %b want 0 0", done, busy); end
    endtask

    task automatic test_reset_mid_run;
        @(negedge clk); op = MUL; a = 16'h1234; b = 16'h0055; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b want 1", busy); end
        rst = 1'b1; #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrun_rst_flags got busy %b done %b want 0 0", busy, done); end
        checks++; if (result !== 16'h0 || zero !== 1'b1) begin errors++; $display("FAIL midrun_rst_result got %h/%b want 0000/1", result, zero); end
        @(negedge clk); rst = 1'b0; op = ADD; a = 16'h0002; b = 16'h0003; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        checks++; if (done !== 1'b1 || result !== 16'h0005) begin
            errors++; $display("FAIL post_rst_add got done %b %h want 1 0005", done, result); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk); op = SLT; a = 16'h0005; b = 16'hFFFF; start = 1'b1;
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || result !== 16'h0001) begin
            errors++; $display("FAIL b2b_slt got done %b %h want 1 0001", done, result); end
        @(negedge clk); op = OR_; a = 16'h00F0; b = 16'h0F00;
        @(posedge clk); #1; start = 1'b0;
        checks++; if (done !== 1'b1 || result !== 16'h0FF0) begin
            errors++; $display("FAIL b2b_or got done %b %h want 1 0ff0", done, result); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || result !== 16'h0FF0) begin
            errors++; $display("FAIL b2b_idle got done %b %h want 0 0ff0", done, result); end
    endtask

    initial begin
        test_reset();
        test_simple();
        test_shift();
        test_mul();
        test_div();
        test_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mc_alu.md
MC_ALU -- requirements
Module: mc_alu

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand/result width in bits (even, >= 8).
REQ-002 SHALL have parameter: SHW, $clog2(WIDTH), width of the shift-amount compare field.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port: start  input  1  operation request, sampled only when busy=0.
REQ-006 SHALL have port: op  input  4  operation code.
REQ-007 SHALL have port: a  input  WIDTH  src1, signed two's complement.
REQ-008 SHALL have port: b  input  WIDTH  src2, signed two's complement.
REQ-009 SHALL have port: busy  output  1  high while a multi-cycle operation runs.
REQ-010 SHALL have port: done  output  1  one-cycle pulse marking result/result_hi/zero/div_by_zero valid.
REQ-011 SHALL have port: result  output  WIDTH  primary result (low product, quotient, or simple-op result).
REQ-012 SHALL have port: result_hi  output  WIDTH  high product or remainder; 0 for simple ops.
REQ-013 SHALL have port: zero  output  1  high when result == 0.
REQ-014 SHALL have port: div_by_zero  output  1  high when the completed op was DIV with b == 0.

Function
REQ-015 SHALL decode op: 0000 add a+b; 0001 sub b-a; 0010 and; 0011 or; 0101 sll a<<b; 0110 srl a>>b (logical); 0111 slt (1 if signed b<a else 0); 1000 MUL; 1001 DIV.
REQ-016 SHALL treat every other op code as undefined: result 0, result_hi 0, zero 1, latency 1.
REQ-017 SHALL implement FSM states IDLE, RUN, DONE; busy=1 only in RUN; done=1 only in DONE.
REQ-018 SHALL, when start=1 in IDLE or DONE, latch op, a and b at that edge; later changes to inputs have no effect on the running operation.
REQ-019 SHALL ignore start while in RUN (no restart, no queueing).
REQ-020 SHALL complete simple ops and undefined ops in one cycle: start edge -> DONE in the following cycle.
REQ-021 SHALL perform MUL as iterative shift-add over WIDTH RUN cycles: done high WIDTH+1 cycles after the start edge.
REQ-022 SHALL produce a signed 2*WIDTH product: low half on result, high half on result_hi.
REQ-023 SHALL return result = 0 for sll/srl when unsigned b >= WIDTH.
REQ-024 SHALL compute add/sub modulo 2^WIDTH with no overflow flag.
REQ-025 SHALL register result, result_hi, zero and div_by_zero on entry to DONE and hold them until the next DONE.
REQ-026 SHALL transition DONE -> IDLE after one cycle unless start=1, in which case it accepts the new op (back-to-back).

Reset
REQ-027 SHALL, on rst=1 at any time including mid-RUN, abort the operation and enter IDLE immediately.
REQ-028 SHALL reset outputs to: busy 0, done 0, result 0, result_hi 0, zero 1, div_by_zero 0.
REQ-029 SHALL accept a start on the first rising clk edge after rst deasserts.

Configuration
REQ-030 SHALL compile the DIV operation in only when macro MC_ALU_DIV_EN is defined.
REQ-031 SHALL, with MC_ALU_DIV_EN defined, perform restoring signed division a/b over WIDTH RUN cycles (latency WIDTH+1); quotient truncates toward zero; remainder takes the sign of a.
REQ-032 SHALL, with MC_ALU_DIV_EN defined and b == 0, skip RUN and report in one cycle: result all ones, result_hi = a, div_by_zero 1.
REQ-033 SHALL, with MC_ALU_DIV_EN defined, return result = most-negative value and result_hi 0 for most-negative / -1.
REQ-034 SHALL, without MC_ALU_DIV_EN, treat op 1001 as undefined (REQ-016), with div_by_zero held at 0 and no divider logic present.

Verification (WIDTH=16)
REQ-035 SHALL cover: add a=0x7FFF b=0x0001 -> done 1 cycle after start, result 0x8000, zero 0.
REQ-036 SHALL cover: MUL a=0xFFFD (-3) b=0x0007 -> done 17 cycles after start, result 0xFFEB, result_hi 0xFFFF, busy high for 16 cycles.
REQ-037 SHALL cover (DIV_EN): DIV a=0xFFF9 (-7) b=0x0002 -> done after 17 cycles, result 0xFFFD, result_hi 0xFFFF; repeat b=0 -> done after 1 cycle, result 0xFFFF, result_hi 0xFFF9, div_by_zero 1.
REQ-038 SHALL cover: rst pulse at 5th RUN cycle of MUL -> busy 0, done 0, result 0, zero 1 immediately; new add 2+3 -> result 0x0005.
REQ-039 SHALL cover: sll a=0x0001 b=0x0010 -> result 0x0000, zero 1; start with op add pulsed during a MUL RUN -> ignored, MUL result unaffected.
REQ-040 SHALL cover: back-to-back start held in DONE of slt a=5 b=-1 (result 1) -> next op or a=0x00F0 b=0x0F00 completes 1 cycle later with result 0x0FF0.
